// File: rtl/vec_bias_adder.sv
// Multi-channel FP32 bias adder/subtractor: one shared two-cycle fpu is time-multiplexed
// across NUM_CH channels, channel 0 first, under a four-phase start/done handshake.

module fpu (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start_i,
    input  logic [2:0]  fpu_op_i,
    input  logic [1:0]  rmode_i,
    input  logic [31:0] opa_i,
    input  logic [31:0] opb_i,
    output logic [31:0] output_o,
    output logic        ready_o,
    output logic        overflow_o,
    output logic        qnan_o,
    output logic        snan_o
);
    logic [31:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d, res_c;
    logic        sub_q, sub_d, bad_q, bad_d, pend_q, pend_d, ready_q, ready_d;
    logic        ovf_q, ovf_d, qnan_q, qnan_d, snan_q, snan_d;
    logic        sa, sb, sx, sy, a_nan, b_nan, a_inf, b_inf, inv, ovf_c, qnan_c, snan_c;
    logic [7:0]  ex, ey, ex1, ey1, dexp;
    logic [22:0] fx, fy;
    logic [26:0] mxe, mye, mys, norm;
    logic [27:0] sum;
    logic [9:0]  lz, sh, e;
    logic [24:0] mr;

    always_comb begin
        sa    = opa_q[31];
        sb    = opb_q[31] ^ sub_q;
        a_nan = (&opa_q[30:23]) && (|opa_q[22:0]);
        b_nan = (&opb_q[30:23]) && (|opb_q[22:0]);
        a_inf = (&opa_q[30:23]) && !(|opa_q[22:0]);
        b_inf = (&opb_q[30:23]) && !(|opb_q[22:0]);
        snan_c = (a_nan && !opa_q[22]) || (b_nan && !opb_q[22]);
        if (opb_q[30:0] > opa_q[30:0]) begin
            {sx, ex, fx} = {sb, opb_q[30:0]};
            {sy, ey, fy} = {sa, opa_q[30:0]};
        end else begin
            {sx, ex, fx} = {sa, opa_q[30:0]};
            {sy, ey, fy} = {sb, opb_q[30:0]};
        end
        ex1  = (ex == 8'd0) ? 8'd1 : ex;
        ey1  = (ey == 8'd0) ? 8'd1 : ey;
        dexp = ex1 - ey1;
        mxe  = {(ex != 8'd0), fx, 3'b000};
        mye  = {(ey != 8'd0), fy, 3'b000};
        // The smaller operand's discarded bits collapse into a sticky LSB for round-to-nearest-even.
        if (dexp >= 8'd27) mys = {26'd0, |mye};
        else mys = (mye >> dexp) | {26'd0, |(mye & ~({27{1'b1}} << dexp))};
        sum = (sx == sy) ? {1'b0, mxe} + {1'b0, mys} : {1'b0, mxe} - {1'b0, mys};
        lz = 10'd27;
        for (int i = 0; i < 27; i++) if (sum[i]) lz = 10'(26 - i);
        sh = 10'd0;
        if (sum[27]) begin
            norm = {sum[27:2], sum[1] | sum[0]};
            e    = {2'b00, ex1} + 10'd1;
        end else begin
            // Left shift stops at exponent 1 so tiny results land as denormals.
            sh   = (lz > {2'b00, ex1} - 10'd1) ? {2'b00, ex1} - 10'd1 : lz;
            norm = sum[26:0] << sh;
            e    = {2'b00, ex1} - sh;
        end
        mr = {1'b0, norm[26:3]} + {24'd0, norm[2] & (norm[3] | norm[1] | norm[0])};
        if (mr[24]) begin
            mr = mr >> 1;
            e  = e + 10'd1;
        end
        inv    = a_nan || b_nan || (a_inf && b_inf && (sa != sb)) || bad_q;
        ovf_c  = 1'b0;
        qnan_c = 1'b0;
        if (inv) begin
            res_c  = 32'h7FC0_0000;
            qnan_c = 1'b1;
        end else if (a_inf) res_c = {sa, 8'hFF, 23'd0};
        else if (b_inf) res_c = {sb, 8'hFF, 23'd0};
        else if (sum == 28'd0) res_c = {sa & sb, 31'd0};
        else if (e >= 10'd255) begin
            res_c = {sx, 8'hFF, 23'd0};
            ovf_c = 1'b1;
        end else res_c = {sx, mr[23] ? e[7:0] : 8'h00, mr[22:0]};
    end

    always_comb begin
        opa_d = opa_q; opb_d = opb_q; sub_d = sub_q; bad_d = bad_q;
        res_d = res_q; ovf_d = ovf_q; qnan_d = qnan_q; snan_d = snan_q;
        ready_d = ready_q;
        pend_d  = 1'b0;
        if (start_i) begin
            opa_d   = opa_i;
            opb_d   = opb_i;
            sub_d   = fpu_op_i[0];
            bad_d   = |{fpu_op_i[2:1], rmode_i};
            pend_d  = 1'b1;
            ready_d = 1'b0;
        end else if (pend_q) begin
            res_d   = res_c;
            ovf_d   = ovf_c;
            qnan_d  = qnan_c;
            snan_d  = snan_c;
            ready_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            opa_q <= '0; opb_q <= '0; sub_q <= 1'b0; bad_q <= 1'b0; res_q <= '0;
            ovf_q <= 1'b0; qnan_q <= 1'b0; snan_q <= 1'b0; pend_q <= 1'b0; ready_q <= 1'b0;
        end else begin
            opa_q <= opa_d; opb_q <= opb_d; sub_q <= sub_d; bad_q <= bad_d; res_q <= res_d;
            ovf_q <= ovf_d; qnan_q <= qnan_d; snan_q <= snan_d; pend_q <= pend_d; ready_q <= ready_d;
        end
    end

    assign output_o   = res_q;
    assign ready_o    = ready_q;
    assign overflow_o = ovf_q;
    assign qnan_o     = qnan_q;
    assign snan_o     = snan_q;
endmodule

module vec_bias_adder #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         start,
    input  logic                         sub,
    input  logic [NUM_CH*DATA_WIDTH-1:0] values_in,
    input  logic [NUM_CH*DATA_WIDTH-1:0] biases_in,
    output logic [NUM_CH*DATA_WIDTH-1:0] values_out,
    output logic                         busy,
    output logic                         done,
    output logic                         ovf_flag,
    output logic                         nan_flag
);
    localparam int CH_W = $clog2(NUM_CH) + 1;
    localparam int VW   = NUM_CH * DATA_WIDTH;
    localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_ISSUE = 3'd2, S_DONE = 3'd3;

    logic [2:0]            state_q, state_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    logic [VW-1:0]         val_q, val_d, bias_q, bias_d, out_q, out_d;
    logic                  sub_q, sub_d, busy_q, busy_d, ovf_q, ovf_d, nan_q, nan_d;
    logic                  fpu_start_q, fpu_start_d;
    logic [DATA_WIDTH-1:0] fpu_opa, fpu_opb, fpu_res;
    logic                  fpu_ready, fpu_ovf, fpu_qnan, fpu_snan;

    fpu u_fpu (
        .clk(clk), .rstn(rstn), .start_i(fpu_start_q), .fpu_op_i({2'b00, sub_q}),
        .rmode_i(2'b00), .opa_i(fpu_opa), .opb_i(fpu_opb), .output_o(fpu_res),
        .ready_o(fpu_ready), .overflow_o(fpu_ovf), .qnan_o(fpu_qnan), .snan_o(fpu_snan)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE; ch_q <= '0; val_q <= '0; bias_q <= '0; out_q <= '0;
            sub_q <= 1'b0; busy_q <= 1'b0; ovf_q <= 1'b0; nan_q <= 1'b0; fpu_start_q <= 1'b0;
        end else begin
            state_q <= state_d; ch_q <= ch_d; val_q <= val_d; bias_q <= bias_d; out_q <= out_d;
            sub_q <= sub_d; busy_q <= busy_d; ovf_q <= ovf_d; nan_q <= nan_d; fpu_start_q <= fpu_start_d;
        end
    end

    always_comb begin
        state_d = state_q; ch_d = ch_q; val_d = val_q; bias_d = bias_q; out_d = out_q;
        sub_d = sub_q; busy_d = busy_q; ovf_d = ovf_q; nan_d = nan_q;
        fpu_start_d = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                val_d = values_in; bias_d = biases_in; sub_d = sub;
                ch_d = '0; ovf_d = 1'b0; nan_d = 1'b0;
                fpu_start_d = 1'b1; busy_d = 1'b1; state_d = S_WAIT;
            end
            // ready_o still reflects the previous operation while our start pulse is in flight.
            S_WAIT: if (fpu_ready && !fpu_start_q) begin
                for (int c = 0; c < NUM_CH; c++)
                    if (ch_q == CH_W'(c)) out_d[c*DATA_WIDTH +: DATA_WIDTH] = fpu_res;
                ovf_d = ovf_q | fpu_ovf;
                nan_d = nan_q | fpu_qnan | fpu_snan;
                if (ch_q == CH_W'(NUM_CH - 1)) begin
                    busy_d = 1'b0; state_d = S_DONE;
                end else begin
                    ch_d = ch_q + CH_W'(1); state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                fpu_start_d = 1'b1; state_d = S_WAIT;
            end
            S_DONE: if (!start) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        done    = (state_q == S_DONE);
        fpu_opa = '0;
        fpu_opb = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (ch_q == CH_W'(c)) begin
                fpu_opa = val_q[c*DATA_WIDTH +: DATA_WIDTH];
                fpu_opb = bias_q[c*DATA_WIDTH +: DATA_WIDTH];
            end
    end

    assign values_out = out_q;
    assign busy       = busy_q;
    assign ovf_flag   = ovf_q;
    assign nan_flag   = nan_q;
endmodule

// File: tb/tb_vec_bias_adder.sv
// Directed bench for vec_bias_adder: 4-channel build plus 1- and 7-channel builds checked
// against an exact double-precision model rounded back to single precision.
module tb_vec_bias_adder;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start4 = 1'b0, sub4 = 1'b0, busy4, done4, ovf4, nan4;
  logic [127:0] vin4 = '0, bin4 = '0, vout4;
  logic start1 = 1'b0, sub1 = 1'b0, busy1, done1, ovf1, nan1;
  logic [31:0] vin1 = '0, bin1 = '0, vout1;
  logic start7 = 1'b0, sub7 = 1'b0, busy7, done7, ovf7, nan7;
  logic [223:0] vin7 = '0, bin7 = '0, vout7;
  logic [31:0] exp_q[$];
  int n_chk = 0;
  int n_err = 0;

  localparam logic [127:0] V1 = {32'h0000_0000, 32'hC060_0000, 32'h4000_0000, 32'h3F80_0000};
  localparam logic [127:0] B1 = {4{32'h3F00_0000}};
  localparam logic [127:0] V3 = {32'h0000_0000, 32'h7F7F_FFFF, 32'h4000_0000, 32'h3F80_0000};
  localparam logic [127:0] B3 = {32'h3F00_0000, 32'h7F7F_FFFF, 32'h3F00_0000, 32'h3F00_0000};
  localparam logic [127:0] VN = {32'h0000_0000, 32'hC060_0000, 32'h4000_0000, 32'h7F80_0000};
  localparam logic [127:0] BN = {32'h3F00_0000, 32'h3F00_0000, 32'h3F00_0000, 32'h7F80_0000};

  vec_bias_adder #(.DATA_WIDTH(32), .NUM_CH(4)) dut (
    .clk(clk), .rstn(rstn), .start(start4), .sub(sub4), .values_in(vin4), .biases_in(bin4),
    .values_out(vout4), .busy(busy4), .done(done4), .ovf_flag(ovf4), .nan_flag(nan4));
  vec_bias_adder #(.DATA_WIDTH(32), .NUM_CH(1)) dut1 (
    .clk(clk), .rstn(rstn), .start(start1), .sub(sub1), .values_in(vin1), .biases_in(bin1),
    .values_out(vout1), .busy(busy1), .done(done1), .ovf_flag(ovf1), .nan_flag(nan1));
  vec_bias_adder #(.DATA_WIDTH(32), .NUM_CH(7)) dut7 (
    .clk(clk), .rstn(rstn), .start(start7), .sub(sub7), .values_in(vin7), .biases_in(bin7),
    .values_out(vout7), .busy(busy7), .done(done7), .ovf_flag(ovf7), .nan_flag(nan7));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic real to_real(input logic [31:0] f);
    return $bitstoreal({f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] to_f32(input real r);
    logic [63:0] d;
    logic [10:0] e;
    logic [30:0] mag;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    mag = {e[7:0], d[51:29]} + 31'(d[28] & ((|d[27:0]) | d[29]));
    return {d[63], mag};
  endfunction

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    return s ? to_f32(to_real(a) - to_real(b)) : to_f32(to_real(a) + to_real(b));
  endfunction

  function automatic logic [31:0] rnd_f();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)};
  endfunction

  task automatic go4(input logic [127:0] v, input logic [127:0] b, input logic s);
    @(negedge clk);
    vin4 = v; bin4 = b; sub4 = s; start4 = 1'b1;
  endtask

  // Counts negedges until done; latency is measured from the negedge that raised start.
  task automatic wait_dut(input int which, input int exp_cyc, input string tag);
    int cyc = 0;
    logic d;
    logic bz;
    d = 1'b0;
    while (!d && cyc < 600) begin
      @(negedge clk);
      cyc++;
      d  = (which == 4) ? done4 : (which == 7) ? done7 : done1;
      bz = (which == 4) ? busy4 : (which == 7) ? busy7 : busy1;
      if (cyc == 2) check({tag, "_busy"}, bz, 1'b1);
    end
    check({tag, "_latency"}, cyc, exp_cyc);
  endtask

  task automatic check_out4(input string tag);
    for (int c = 0; c < 4; c++)
      check($sformatf("%s_ch%0d", tag, c), vout4[c*32 +: 32], exp_q.pop_front());
  endtask

  task automatic push4(input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] r3);
    exp_q.push_back(r0); exp_q.push_back(r1); exp_q.push_back(r2); exp_q.push_back(r3);
  endtask

  task automatic release4();
    start4 = 1'b0;
    @(negedge clk);
    check("idle_done", done4, 1'b0);
  endtask

  initial begin
    int found;
    repeat (3) @(negedge clk);
    check("rst_vout", vout4, 128'd0);
    check("rst_busy", busy4, 1'b0);
    check("rst_done", done4, 1'b0);
    check("rst_flags", {ovf4, nan4}, 2'b00);
    rstn = 1'b1;

    go4(V1, B1, 1'b0);
    push4(32'h3FC0_0000, 32'h4020_0000, 32'hC040_0000, 32'h3F00_0000);
    wait_dut(4, 16, "add");
    check_out4("add");
    check("add_flags", {ovf4, nan4, busy4}, 3'b000);
    release4();

    go4(V1, B1, 1'b1);
    push4(32'h3F00_0000, 32'h3FC0_0000, 32'hC080_0000, 32'hBF00_0000);
    wait_dut(4, 16, "sub");
    check_out4("sub");
    release4();

    go4(V3, B3, 1'b0);
    push4(32'h3FC0_0000, 32'h4020_0000, 32'h7F80_0000, 32'h3F00_0000);
    wait_dut(4, 16, "ovf");
    check_out4("ovf");
    check("ovf_flags", {ovf4, nan4}, 2'b10);
    release4();
    check("ovf_sticky_idle", ovf4, 1'b1);
    go4(V1, B1, 1'b0);
    @(negedge clk);
    check("ovf_clear_accept", ovf4, 1'b0);
    push4(32'h3FC0_0000, 32'h4020_0000, 32'hC040_0000, 32'h3F00_0000);
    wait_dut(4, 15, "clean");
    check_out4("clean");
    check("clean_flags", {ovf4, nan4}, 2'b00);
    release4();

    go4(VN, BN, 1'b1);
    push4(32'h7FC0_0000, 32'h3FC0_0000, 32'hC080_0000, 32'hBF00_0000);
    wait_dut(4, 16, "nan");
    check_out4("nan");
    check("nan_flags", {ovf4, nan4}, 2'b01);
    release4();

    go4(V1, B1, 1'b0);
    @(negedge clk);
    start4 = 1'b0; vin4 = {4{32'h4100_0000}}; bin4 = {4{32'h4040_0000}}; sub4 = 1'b1;
    push4(32'h3FC0_0000, 32'h4020_0000, 32'hC040_0000, 32'h3F00_0000);
    wait_dut(4, 15, "drop");
    check_out4("drop");
    @(negedge clk);
    check("drop_done_pulse", done4, 1'b0);

    go4(V1, B1, 1'b1);
    push4(32'h3F00_0000, 32'h3FC0_0000, 32'hC080_0000, 32'hBF00_0000);
    wait_dut(4, 16, "hold");
    repeat (20) @(negedge clk);
    check("hold_done", {done4, busy4}, 2'b10);
    check_out4("hold");
    release4();

    go4(V3, B3, 1'b0);
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      @(negedge clk);
      if (dut.state_q == 3'd1 && dut.ch_q == 3'd2) found = 1;
    end
    check("rst_mid_reach", found, 1);
    rstn = 1'b0;
    start4 = 1'b0;
    #1;
    check("rst_mid_vout", vout4, 128'd0);
    check("rst_mid_ctl", {busy4, done4, ovf4, nan4}, 4'b0000);
    @(negedge clk);
    check("rst_mid_state", {dut.state_q, dut.ch_q}, 6'd0);
    rstn = 1'b1;
    go4(V1, B1, 1'b1);
    push4(32'h3F00_0000, 32'h3FC0_0000, 32'hC080_0000, 32'hBF00_0000);
    wait_dut(4, 16, "after_rst");
    check_out4("after_rst");
    release4();

    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      sub7 = 1'($urandom_range(0, 1));
      for (int c = 0; c < 7; c++) begin
        vin7[c*32 +: 32] = rnd_f();
        bin7[c*32 +: 32] = rnd_f();
        exp_q.push_back(model(vin7[c*32 +: 32], bin7[c*32 +: 32], sub7));
      end
      start7 = 1'b1;
      @(negedge clk);
      for (int c = 0; c < 7; c++) vin7[c*32 +: 32] = rnd_f();
      sub7 = ~sub7;
      wait_dut(7, 27, $sformatf("c7_t%0d", t));
      for (int c = 0; c < 7; c++)
        check($sformatf("c7_t%0d_ch%0d", t, c), vout7[c*32 +: 32], exp_q.pop_front());
      check("c7_flags", {ovf7, nan7}, 2'b00);
      start7 = 1'b0;
      @(negedge clk);
    end

    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      vin1 = rnd_f(); bin1 = rnd_f(); sub1 = 1'(t % 2);
      exp_q.push_back(model(vin1, bin1, sub1));
      start1 = 1'b1;
      wait_dut(1, 4, $sformatf("c1_t%0d", t));
      check($sformatf("c1_t%0d_res", t), vout1, exp_q.pop_front());
      start1 = 1'b0;
      @(negedge clk);
    end

    check("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
